// File: rtl/led_event_scheduler_pkg.sv
// Shared types and board timing constants for the LED event scheduler.
// Cycle counts assume the 50 MHz board clock.
package led_event_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ON,
      ST_OFF,
      ST_GAP
   } led_state_t;

   localparam int unsigned CYC_100MS = 5_000_000;
   localparam int unsigned CYC_400MS = 20_000_000;

endpackage

// File: rtl/led_event_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx
);

   int idx;

   // Scan from the far end so the closest request to ptr wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = W'(idx);
         end
      end
   end

endmodule

// File: rtl/led_event_scheduler.sv
// One status LED shared by several event sources; source i blinks i+1
// times followed by a dark gap, sources served round-robin.
module led_event_scheduler
   import led_event_scheduler_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = 2,
   parameter int CNT_W   = 25,
   parameter int ON_LEN  = CYC_100MS,
   parameter int OFF_LEN = CYC_100MS,
   parameter int GAP_LEN = CYC_400MS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_SRC-1:0] event_in,
   output logic               led,
   output logic               busy,
   output logic [SRC_W-1:0]   cur_src,
   output logic [NUM_SRC-1:0] pending
);

   localparam logic [CNT_W-1:0] ON_END  = CNT_W'(ON_LEN - 1);
   localparam logic [CNT_W-1:0] OFF_END = CNT_W'(OFF_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_END = CNT_W'(GAP_LEN - 1);
   localparam logic [SRC_W-1:0] LAST    = SRC_W'(NUM_SRC - 1);

   led_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SRC_W-1:0]   blinks_q, blinks_d;
   logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0]   src_q, src_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] clr;
   logic               led_q, led_d;
   logic               busy_q, busy_d;
   logic               gnt_valid;
   logic [SRC_W-1:0]   gnt_idx;

   rr_arbiter #(
      .N (NUM_SRC),
      .W (SRC_W)
   ) u_arb (
      .req       (pend_q),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         blinks_q <= '0;
         rr_ptr_q <= '0;
         src_q    <= '0;
         pend_q   <= '0;
         led_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         blinks_q <= blinks_d;
         rr_ptr_q <= rr_ptr_d;
         src_q    <= src_d;
         pend_q   <= pend_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      blinks_d = blinks_q;
      rr_ptr_d = rr_ptr_q;
      src_d    = src_q;
      led_d    = led_q;
      busy_d   = busy_q;
      clr      = '0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable && gnt_valid) begin
               state_d      = ST_ON;
               led_d        = 1'b1;
               busy_d       = 1'b1;
               src_d        = gnt_idx;
               blinks_d     = gnt_idx;
               clr[gnt_idx] = 1'b1;
               rr_ptr_d     = (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
            end
         end
         ST_ON: begin
            if (cnt_q == ON_END) begin
               state_d = ST_OFF;
               cnt_d   = '0;
               led_d   = 1'b0;
            end
         end
         ST_OFF: begin
            if (cnt_q == OFF_END) begin
               cnt_d = '0;
               if (blinks_q != '0) begin
                  blinks_d = blinks_q - 1'b1;
                  state_d  = ST_ON;
                  led_d    = 1'b1;
               end else begin
                  state_d = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_END) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Dropping enable discards the code in flight.
      if (!enable && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         led_d   = 1'b0;
         busy_d  = 1'b0;
      end
      // A new event on the granted source wins over the grant's clear.
      pend_d = (pend_q & ~clr) | event_in;
   end

   assign led     = led_q;
   assign busy    = busy_q;
   assign cur_src = src_q;
   assign pending = pend_q;

endmodule
